// File: rtl/ed25519_pkg.sv
// ed25519_pkg: shared field-element types, limb slicing, FSM states and limbwise add/sub.
// Field elements are 10 signed 32-bit limbs (radix 2^25.5); limb 0 sits at the MSB end.
// The state enum depends on GE_ADD_PAR_MUL_EN (two multipliers, fewer MUL states).
package ed25519_pkg;
  localparam int NLIMB = 10;
  localparam int LW = 32;
  localparam int FE_W = NLIMB * LW;
  typedef logic [FE_W-1:0] fe_t;
  localparam fe_t FE_ZERO = '0;
  localparam fe_t FE_ONE = {32'd1, 288'd0};
`ifdef GE_ADD_PAR_MUL_EN
  typedef enum logic [2:0] {IDLE, ADDSUB, MULA, MULB, COMB, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDSUB, MUL0, MUL1, MUL2, MUL3, COMB, DONE} state_t;
`endif
  function automatic int limb_lo(int i);
    return (NLIMB - 1 - i) * LW;
  endfunction
  function automatic logic signed [LW-1:0] limb(fe_t x, int i);
    return x[limb_lo(i) +: LW];
  endfunction
  function automatic fe_t fe_add(fe_t x, fe_t y);
    fe_t r;
    for (int i = 0; i < NLIMB; i++) r[limb_lo(i) +: LW] = x[limb_lo(i) +: LW] + y[limb_lo(i) +: LW];
    return r;
  endfunction
  function automatic fe_t fe_sub(fe_t x, fe_t y);
    fe_t r;
    for (int i = 0; i < NLIMB; i++) r[limb_lo(i) +: LW] = x[limb_lo(i) +: LW] - y[limb_lo(i) +: LW];
    return r;
  endfunction
endpackage

// File: rtl/ed25519_fe_mul.sv
// ed25519_fe_mul: combinational field multiply, bit-exact to ref10 fe_mul.
// Ports: f, g - operands; h - product with ref10 carry chain applied.
module ed25519_fe_mul
  import ed25519_pkg::*;
(
  input  fe_t f,
  input  fe_t g,
  output fe_t h
);
  // Limb indices of the ref10 carry sequence 0,4,1,5,2,6,3,7,4,8,9,0, one nibble each.
  localparam logic [47:0] ORD = 48'h041526374890;
  function automatic fe_t mul(fe_t x, fe_t y);
    logic signed [63:0] acc [NLIMB];
    logic signed [63:0] p, cy;
    logic [3:0] l;
    logic [4:0] s;
    fe_t r;
    for (int i = 0; i < NLIMB; i++) acc[i] = '0;
    for (int i = 0; i < NLIMB; i++)
      for (int j = 0; j < NLIMB; j++) begin
        p = 64'(limb(x, i)) * 64'(limb(y, j));
        // Odd limbs carry an extra half bit of weight, so odd*odd terms double.
        if (i % 2 == 1 && j % 2 == 1) p = p <<< 1;
        // 2^255 = 19 mod p: wrapped terms fold back scaled by 19.
        if (i + j >= NLIMB) p = p * 64'sd19;
        acc[(i + j) % NLIMB] += p;
      end
    for (int n = 0; n < 12; n++) begin
      l = ORD[4*(11-n) +: 4];
      s = l[0] ? 5'd25 : 5'd26;
      cy = (acc[l] + (64'sd1 <<< (s - 5'd1))) >>> s;
      if (l == 4'd9) acc[0] += cy * 64'sd19;
      else acc[l + 4'd1] += cy;
      acc[l] -= cy <<< s;
    end
    for (int i = 0; i < NLIMB; i++) r[limb_lo(i) +: LW] = acc[i][LW-1:0];
    return r;
  endfunction
  assign h = mul(f, g);
endmodule

// File: rtl/ed25519_ge_add.sv
// ed25519_ge_add: ref10 ge_add, extended P plus cached Q giving completed (p1p1) R.
// Ports: clk; rst (sync, active-low); p_x/p_y/p_z/p_t; q_yplusx/q_yminusx/q_z/q_t2d;
//   valid (start, accepted in IDLE or DONE); r_x/r_y/r_z/r_t; done (level, held in DONE).
// GE_ADD_PAR_MUL_EN: two multipliers, done 5 edges after valid instead of 7.
module ed25519_ge_add
  import ed25519_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  fe_t  p_x,
  input  fe_t  p_y,
  input  fe_t  p_z,
  input  fe_t  p_t,
  input  fe_t  q_yplusx,
  input  fe_t  q_yminusx,
  input  fe_t  q_z,
  input  fe_t  q_t2d,
  input  logic valid,
  output fe_t  r_x,
  output fe_t  r_y,
  output fe_t  r_z,
  output fe_t  r_t,
  output logic done
);
  state_t state, state_n;
  fe_t px, py, pz, pt, qyp, qym, qz, qt;
  fe_t a, b, c, e, f, g, t0;
  fe_t m0_a, m0_b, m0_y;
  logic accept, busy;
  assign accept = valid && (state == IDLE || state == DONE);
  assign busy = state != IDLE && state != DONE;
  assign t0 = fe_add(g, g);
  // Busy states are consecutive in the enum, so the datapath just steps forward.
  always_comb begin
    state_n = state;
    if (accept) state_n = ADDSUB;
    else if (busy) state_n = state_t'(state + 3'd1);
  end
  ed25519_fe_mul u_mul0 (.f(m0_a), .g(m0_b), .h(m0_y));
`ifdef GE_ADD_PAR_MUL_EN
  fe_t m1_a, m1_b, m1_y;
  assign m0_a = state == MULA ? a : qt;
  assign m0_b = state == MULA ? qyp : pt;
  assign m1_a = state == MULA ? b : pz;
  assign m1_b = state == MULA ? qym : qz;
  ed25519_fe_mul u_mul1 (.f(m1_a), .g(m1_b), .h(m1_y));
`else
  assign m0_a = state == MUL0 ? a : state == MUL1 ? b : state == MUL2 ? qt : pz;
  assign m0_b = state == MUL0 ? qyp : state == MUL1 ? qym : state == MUL2 ? pt : qz;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      done <= 1'b0;
      {px, py, pz, pt, qyp, qym, qz, qt} <= '0;
      {a, b, c, e, f, g} <= '0;
      {r_x, r_y, r_z, r_t} <= '0;
    end else begin
      state <= state_n;
      // done follows DONE one edge late and drops on the edge that accepts new work.
      done <= state == DONE && !valid;
      if (accept) {px, py, pz, pt, qyp, qym, qz, qt} <= {p_x, p_y, p_z, p_t, q_yplusx, q_yminusx, q_z, q_t2d};
      if (state == ADDSUB) begin
        a <= fe_add(py, px);
        b <= fe_sub(py, px);
      end
`ifdef GE_ADD_PAR_MUL_EN
      if (state == MULA) begin
        c <= m0_y;
        e <= m1_y;
      end
      if (state == MULB) begin
        f <= m0_y;
        g <= m1_y;
      end
`else
      if (state == MUL0) c <= m0_y;
      if (state == MUL1) e <= m0_y;
      if (state == MUL2) f <= m0_y;
      if (state == MUL3) g <= m0_y;
`endif
      if (state == COMB) begin
        r_x <= fe_sub(c, e);
        r_y <= fe_add(c, e);
        r_z <= fe_add(t0, f);
        r_t <= fe_sub(t0, f);
      end
    end
  end
endmodule

// File: tb/tb_ed25519_ge_add.sv
// tb_ed25519_ge_add: directed-vector bench for ed25519_ge_add (identity, KAT, busy, reset, back-to-back).
module tb_ed25519_ge_add;
  import ed25519_pkg::*;
`ifdef GE_ADD_PAR_MUL_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 7;
`endif
  localparam fe_t ONE = {32'd1, 288'd0};
  localparam fe_t TWO = {32'd2, 288'd0};
  localparam fe_t ZERO = '0;
  localparam fe_t K_PX = 320'hfee357b0007f52ebfe377ada0050d0460133cb41ff95f756011d7b40ff8cd6dffff6a71a00a2384e;
  localparam fe_t K_PY = 320'hfea097ea00e087db00624c9200971965ffa199b1ffb5525dfe3ff23f009dfcf2010c44b800577563;
  localparam fe_t K_PZ = 320'hfe6e55e6ff657c15fe3ef28e00dfdbeffe7c6fbbff68221ffe75c13100551e6bffb4de9b005fae49;
  localparam fe_t K_PT = 320'hffdab706ff56ca33fe1fde2400ad90ef01e0d67aff8be8a8fe6ac8ca008772f0fe14ad4100cfa961;
  localparam fe_t K_QP = 320'hffbcaf5f00f20b2efd5a3edaff514f9bfed39b5afee31a21fefb05d7fff31033019e1efbffc3571b;
  localparam fe_t K_QM = 320'h036fe1b5000123640070048e00441801fd8b8db6ffe04875ff03721101558c7fff38924d0042f863;
  localparam fe_t K_QT = 320'hfe07d26d004e2f3600af59a6004b9cb4feb7698900fcfe75feded0e4ff93156500bd54900021897d;
  localparam fe_t K_RX = 320'h025192580092303a027e424c014169a901cc4bb00006b28700515d30fe883853fece1c34fe6f9edd;
  localparam fe_t K_RY = 320'h00937912008a833c002f2b8c00933789fe7596fa00ccfc83017c22d8ffb33141fe4e8786006d7d51;
  localparam fe_t K_RZ = 320'hfcb1111afe3e4957fc4ba8e002b6e5c8fd2bf84aff2fbdd3fc53ad8900002b6401220b2e00b8d4f8;
  localparam fe_t K_RT = 320'hfd08467eff57a6fdfcb0215800c889f4fcc5c6a2fe70caa9fd83573b01544e48fdb16f3e00c5e42c;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;
  logic done;
  fe_t p_x, p_y, p_z, p_t, q_yplusx, q_yminusx, q_z, q_t2d;
  fe_t r_x, r_y, r_z, r_t;
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ed25519_ge_add dut (
    .clk(clk), .rst(rst),
    .p_x(p_x), .p_y(p_y), .p_z(p_z), .p_t(p_t),
    .q_yplusx(q_yplusx), .q_yminusx(q_yminusx), .q_z(q_z), .q_t2d(q_t2d),
    .valid(valid),
    .r_x(r_x), .r_y(r_y), .r_z(r_z), .r_t(r_t),
    .done(done)
  );
  task automatic set_identity();
    p_x = ZERO; p_y = ONE; p_z = ONE; p_t = ZERO;
    q_yplusx = ONE; q_yminusx = ONE; q_z = ONE; q_t2d = ZERO;
  endtask
  task automatic set_kat();
    p_x = K_PX; p_y = K_PY; p_z = K_PZ; p_t = K_PT;
    q_yplusx = K_QP; q_yminusx = K_QM; q_z = ONE; q_t2d = K_QT;
  endtask
  task automatic pulse();
    @(negedge clk) valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= LAT + 3 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
  endtask
  task automatic test_reset();
    fe_t got [4];
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    got = '{r_x, r_y, r_z, r_t};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== ZERO) begin errors++; $display("FAIL reset_r[%0d]: got %h want %h", i, got[i], ZERO); end
    end
    rst = 1'b1;
  endtask
  task automatic test_identity();
    fe_t got [4];
    fe_t exp [4];
    int lat;
    set_identity();
    pulse();
    wait_done(lat);
    vectors++;
    if (lat !== LAT) begin errors++; $display("FAIL identity_latency: got %0d want %0d", lat, LAT); end
    got = '{r_x, r_y, r_z, r_t};
    exp = '{ZERO, TWO, TWO, TWO};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL identity_r[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
  endtask
  task automatic test_kat();
    fe_t got [4];
    fe_t exp [4];
    int lat;
    set_kat();
    pulse();
    wait_done(lat);
    vectors++;
    if (lat !== LAT) begin errors++; $display("FAIL kat_latency: got %0d want %0d", lat, LAT); end
    got = '{r_x, r_y, r_z, r_t};
    exp = '{K_RX, K_RY, K_RZ, K_RT};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL kat_r[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
  endtask
  task automatic test_busy_ignore();
    fe_t got [4];
    fe_t exp [4];
    int lat;
    logic dropped;
    set_identity();
    pulse();
    lat = 0;
    for (int k = 1; k <= LAT + 3 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) valid = 1'b0;
      if (done) lat = k;
      if (k == 2) begin
        set_kat();
        valid = 1'b1;
      end
    end
    valid = 1'b0;
    vectors++;
    if (lat !== LAT) begin errors++; $display("FAIL busy_latency: got %0d want %0d", lat, LAT); end
    dropped = 1'b0;
    repeat (LAT + 3) begin
      @(posedge clk);
      #1;
      if (!done) dropped = 1'b1;
    end
    vectors++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL busy_done_held: got drop=%b want 0", dropped); end
    got = '{r_x, r_y, r_z, r_t};
    exp = '{ZERO, TWO, TWO, TWO};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL busy_r[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
  endtask
  task automatic test_reset_midop();
    fe_t got [4];
    logic rose;
    set_kat();
    pulse();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
    got = '{r_x, r_y, r_z, r_t};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== ZERO) begin errors++; $display("FAIL midreset_r[%0d]: got %h want %h", i, got[i], ZERO); end
    end
    rst = 1'b1;
    rose = 1'b0;
    repeat (LAT + 3) begin
      @(posedge clk);
      #1;
      if (done) rose = 1'b1;
    end
    vectors++;
    if (rose !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got rose=%b want 0", rose); end
    test_kat();
  endtask
  task automatic test_back_to_back();
    fe_t got [4];
    fe_t exp [4];
    int lat;
    vectors++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_start_done: got %b want 1", done); end
    set_identity();
    pulse();
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b want 0", done); end
    wait_done(lat);
    vectors++;
    if (lat !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    got = '{r_x, r_y, r_z, r_t};
    exp = '{ZERO, TWO, TWO, TWO};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_r[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
  endtask
  initial begin
    set_identity();
    test_reset();
    test_identity();
    test_kat();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
